// File: rtl/execute_cycle.sv
// Execute stage of the RV32 pipeline: operand forwarding, ALU, branch resolution and the EX/MEM register.
// PCSrcE/PCTargetE resolve in the same cycle; everything else reaches the M stage one clock later.
module execute_cycle (
   input  logic        CLK,
   input  logic        Rst,
   input  logic        RegWriteE,
   input  logic        ALUSrcE,
   input  logic        MemWriteE,
   input  logic        BranchE,
   input  logic        JumpE,
   input  logic        PCResultSrcE,
   input  logic [2:0]  ResultSrcE,
   input  logic [2:0]  DexControlE,
   input  logic [3:0]  ALUControlE,
   input  logic [31:0] RD1_E,
   input  logic [31:0] RD2_E,
   input  logic [31:0] Imm_Ext_E,
   input  logic [31:0] PCE,
   input  logic [31:0] PCPlus4E,
   input  logic [4:0]  RD_E,
   input  logic [1:0]  ForwardAE,
   input  logic [1:0]  ForwardBE,
   input  logic [31:0] ResultW,
   output logic        PCSrcE,
   output logic [31:0] PCTargetE,
   output logic        RegWriteM,
   output logic        MemWriteM,
   output logic [2:0]  ResultSrcM,
   output logic [2:0]  DexControlM,
   output logic [31:0] ALUResultM,
   output logic [31:0] WriteDataM,
   output logic [31:0] Imm_Ext_M,
   output logic [31:0] PCPlus4M,
   output logic [4:0]  RD_M
);

   logic [31:0] srcA;
   logic [31:0] fwdB;
   logic [31:0] srcB;
   logic [31:0] aluResult;
   logic        branchCond;

   // Operand forwarding muxes; select 11 falls back to the register file value.
   always_comb begin
      case (ForwardAE)
         2'b01:   srcA = ResultW;
         2'b10:   srcA = ALUResultM;
         default: srcA = RD1_E;
      endcase
      case (ForwardBE)
         2'b01:   fwdB = ResultW;
         2'b10:   fwdB = ALUResultM;
         default: fwdB = RD2_E;
      endcase
      if (ALUSrcE) begin
         srcB = Imm_Ext_E;
      end else begin
         srcB = fwdB;
      end
   end

   // ALU
   always_comb begin
      case (ALUControlE)
         4'b0000: aluResult = srcA + srcB;
         4'b0001: aluResult = srcA - srcB;
         4'b0010: aluResult = srcA & srcB;
         4'b0011: aluResult = srcA | srcB;
         4'b0100: aluResult = srcA ^ srcB;
         4'b0101: aluResult = {31'd0, $signed(srcA) < $signed(srcB)};
         4'b0110: aluResult = {31'd0, srcA < srcB};
         4'b0111: aluResult = srcA << srcB[4:0];
         4'b1000: aluResult = srcA >> srcB[4:0];
         4'b1001: aluResult = $signed(srcA) >>> srcB[4:0];
         default: aluResult = 32'd0;
      endcase
   end

   // Branch condition always compares against the forwarded rs2, never the immediate.
   always_comb begin
      case (DexControlE)
         3'b000:  branchCond = (srcA == fwdB);
         3'b001:  branchCond = (srcA != fwdB);
         3'b100:  branchCond = ($signed(srcA) < $signed(fwdB));
         3'b101:  branchCond = ($signed(srcA) >= $signed(fwdB));
         3'b110:  branchCond = (srcA < fwdB);
         3'b111:  branchCond = (srcA >= fwdB);
         default: branchCond = 1'b0;
      endcase
   end

   // Redirect decision and target
   always_comb begin
      PCSrcE = (BranchE & branchCond) | JumpE;
      if (PCResultSrcE) begin
         PCTargetE = {aluResult[31:1], 1'b0};
      end else begin
         PCTargetE = PCE + Imm_Ext_E;
      end
   end

   // EX/MEM pipeline register
   always_ff @(posedge CLK or negedge Rst) begin
      if (!Rst) begin
         RegWriteM   <= 1'b0;
         MemWriteM   <= 1'b0;
         ResultSrcM  <= 3'd0;
         DexControlM <= 3'd0;
         ALUResultM  <= 32'd0;
         WriteDataM  <= 32'd0;
         Imm_Ext_M   <= 32'd0;
         PCPlus4M    <= 32'd0;
         RD_M        <= 5'd0;
      end else begin
         RegWriteM   <= RegWriteE;
         MemWriteM   <= MemWriteE;
         ResultSrcM  <= ResultSrcE;
         DexControlM <= DexControlE;
         ALUResultM  <= aluResult;
         WriteDataM  <= fwdB;
         Imm_Ext_M   <= Imm_Ext_E;
         PCPlus4M    <= PCPlus4E;
         RD_M        <= RD_E;
      end
   end

endmodule

// File: tb/tb_execute_cycle.sv
// Bench for execute_cycle: directed scenarios then random instructions, all checked against a behavioural model.
module tb_execute_cycle;

   logic        CLK = 1'b0;
   logic        Rst = 1'b0;
   logic        RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE, PCResultSrcE;
   logic [2:0]  ResultSrcE, DexControlE;
   logic [3:0]  ALUControlE;
   logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
   logic [4:0]  RD_E;
   logic [1:0]  ForwardAE, ForwardBE;
   logic        PCSrcE;
   logic [31:0] PCTargetE;
   logic        RegWriteM, MemWriteM;
   logic [2:0]  ResultSrcM, DexControlM;
   logic [31:0] ALUResultM, WriteDataM, Imm_Ext_M, PCPlus4M;
   logic [4:0]  RD_M;

   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;

   // Model of the M stage contents
   logic        mRegWrite, mMemWrite;
   logic [2:0]  mResultSrc, mDex;
   logic [31:0] mAlu, mWd, mImm, mPc4;
   logic [4:0]  mRd;

   execute_cycle dut (
      .CLK(CLK), .Rst(Rst),
      .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
      .BranchE(BranchE), .JumpE(JumpE), .PCResultSrcE(PCResultSrcE),
      .ResultSrcE(ResultSrcE), .DexControlE(DexControlE), .ALUControlE(ALUControlE),
      .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
      .RD_E(RD_E), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
      .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
      .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
      .ResultSrcM(ResultSrcM), .DexControlM(DexControlM),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .Imm_Ext_M(Imm_Ext_M),
      .PCPlus4M(PCPlus4M), .RD_M(RD_M)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) begin
         passCount++;
      end else begin
         failCount++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf, input logic [31:0] wb, input logic [31:0] mem);
      if (sel == 2'd1) return wb;
      if (sel == 2'd2) return mem;
      return rf;
   endfunction

   function automatic logic [31:0] refAlu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int sh;
      longint sa, sb;
      sh = int'(b % 32);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return (sa < sb) ? 32'd1 : 32'd0;
         4'd6:    return (a < b) ? 32'd1 : 32'd0;
         4'd7:    return a << sh;
         4'd8:    return a >> sh;
         4'd9:    return a[31] ? ((a >> sh) | ~(32'hFFFFFFFF >> sh)) : (a >> sh);
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic refTaken(input logic [2:0] cond, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (cond)
         3'd0:    return a == b;
         3'd1:    return a != b;
         3'd4:    return sa < sb;
         3'd5:    return sa >= sb;
         3'd6:    return a < b;
         3'd7:    return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   task automatic modelClear();
      mRegWrite = 1'b0; mMemWrite = 1'b0; mResultSrc = 3'd0; mDex = 3'd0;
      mAlu = 32'd0; mWd = 32'd0; mImm = 32'd0; mPc4 = 32'd0; mRd = 5'd0;
   endtask

   task automatic checkM(input string tag);
      chk({tag, ".RegWriteM"},   {31'd0, RegWriteM},   {31'd0, mRegWrite});
      chk({tag, ".MemWriteM"},   {31'd0, MemWriteM},   {31'd0, mMemWrite});
      chk({tag, ".ResultSrcM"},  {29'd0, ResultSrcM},  {29'd0, mResultSrc});
      chk({tag, ".DexControlM"}, {29'd0, DexControlM}, {29'd0, mDex});
      chk({tag, ".ALUResultM"},  ALUResultM,           mAlu);
      chk({tag, ".WriteDataM"},  WriteDataM,           mWd);
      chk({tag, ".Imm_Ext_M"},   Imm_Ext_M,            mImm);
      chk({tag, ".PCPlus4M"},    PCPlus4M,             mPc4);
      chk({tag, ".RD_M"},        {27'd0, RD_M},        {27'd0, mRd});
   endtask

   // Called just after a falling edge with E inputs already driven; ends on the next falling edge.
   task automatic step(input string tag);
      logic [31:0] a, fb, b, res, tgt;
      logic        take;
      #1;
      a    = pick(ForwardAE, RD1_E, ResultW, mAlu);
      fb   = pick(ForwardBE, RD2_E, ResultW, mAlu);
      b    = ALUSrcE ? Imm_Ext_E : fb;
      res  = refAlu(ALUControlE, a, b);
      take = (BranchE && refTaken(DexControlE, a, fb)) || JumpE;
      tgt  = PCResultSrcE ? (res & 32'hFFFFFFFE) : (PCE + Imm_Ext_E);
      chk({tag, ".PCSrcE"},    {31'd0, PCSrcE}, {31'd0, take});
      chk({tag, ".PCTargetE"}, PCTargetE,       tgt);
      @(posedge CLK);
      #1;
      mRegWrite = RegWriteE; mMemWrite = MemWriteE; mResultSrc = ResultSrcE; mDex = DexControlE;
      mAlu = res; mWd = fb; mImm = Imm_Ext_E; mPc4 = PCPlus4E; mRd = RD_E;
      checkM(tag);
      @(negedge CLK);
   endtask

   task automatic idle();
      RegWriteE = 1'b0; ALUSrcE = 1'b0; MemWriteE = 1'b0; BranchE = 1'b0; JumpE = 1'b0;
      PCResultSrcE = 1'b0; ResultSrcE = 3'd0; DexControlE = 3'd0; ALUControlE = 4'd0;
      RD1_E = 32'd0; RD2_E = 32'd0; Imm_Ext_E = 32'd0; PCE = 32'd0; PCPlus4E = 32'd0;
      RD_E = 5'd0; ForwardAE = 2'd0; ForwardBE = 2'd0; ResultW = 32'd0;
   endtask

   initial begin
      idle();
      modelClear();
      #2;
      checkM("reset");
      @(negedge CLK);
      @(negedge CLK);
      Rst = 1'b1;

      // ADD wraps
      RD1_E = 32'hFFFFFFFF; RD2_E = 32'd1; RD_E = 5'd3; RegWriteE = 1'b1;
      step("add_wrap");
      chk("add_wrap.const", ALUResultM, 32'h0);

      // Seed ALUResultM = 0x10, then forward it and ResultW
      idle(); RD1_E = 32'h10; ALUSrcE = 1'b1;
      step("seed");
      idle(); ForwardAE = 2'b10; RD1_E = 32'h99; Imm_Ext_E = 32'd4; ALUSrcE = 1'b1;
      ForwardBE = 2'b01; ResultW = 32'hAB; RD2_E = 32'h55; MemWriteE = 1'b1; DexControlE = 3'b010;
      step("fwd");
      chk("fwd.alu_const", ALUResultM, 32'h14);
      chk("fwd.wd_const",  WriteDataM, 32'hAB);

      // BLT taken, BLTU not taken
      idle(); RD1_E = 32'h80000000; RD2_E = 32'd1; BranchE = 1'b1; PCE = 32'h100;
      Imm_Ext_E = 32'hFFFFFFF8; DexControlE = 3'b100; ALUControlE = 4'b0001;
      #1;
      chk("blt.pcsrc_const",  {31'd0, PCSrcE}, 32'd1);
      chk("blt.target_const", PCTargetE,       32'hF8);
      step("blt");
      DexControlE = 3'b110;
      #1;
      chk("bltu.pcsrc_const", {31'd0, PCSrcE}, 32'd0);
      step("bltu");

      // JALR
      idle(); JumpE = 1'b1; PCResultSrcE = 1'b1; RD1_E = 32'h203; Imm_Ext_E = 32'h10; ALUSrcE = 1'b1;
      PCPlus4E = 32'h44; RegWriteE = 1'b1; RD_E = 5'd1; ResultSrcE = 3'b010; PCE = 32'h40;
      #1;
      chk("jalr.pcsrc_const",  {31'd0, PCSrcE}, 32'd1);
      chk("jalr.target_const", PCTargetE,       32'h212);
      step("jalr");
      chk("jalr.pc4_const", PCPlus4M,             32'h44);
      chk("jalr.rw_const",  {31'd0, RegWriteM},   32'd1);

      // SRA uses only the low five shift bits; undefined op yields 0
      idle(); RD1_E = 32'h80000000; Imm_Ext_E = 32'h21; ALUSrcE = 1'b1; ALUControlE = 4'b1001;
      step("sra");
      chk("sra.const", ALUResultM, 32'hC0000000);
      ALUControlE = 4'b1111;
      step("op15");
      chk("op15.const", ALUResultM, 32'h0);

      // Async reset mid-operation
      idle(); RegWriteE = 1'b1; MemWriteE = 1'b1; RD1_E = 32'h1234; RD2_E = 32'h77; RD_E = 5'd9;
      PCPlus4E = 32'h88; Imm_Ext_E = 32'h5; ResultSrcE = 3'd1; DexControlE = 3'd2;
      step("pre_rst");
      #1 Rst = 1'b0;
      #1;
      modelClear();
      chk("rst_async.RegWriteM", {31'd0, RegWriteM}, 32'd0);
      chk("rst_async.MemWriteM", {31'd0, MemWriteM}, 32'd0);
      checkM("rst_async");
      @(posedge CLK);
      #1;
      checkM("rst_hold");
      @(negedge CLK);
      Rst = 1'b1;
      ForwardAE = 2'b10; ALUSrcE = 1'b1; Imm_Ext_E = 32'h3;
      step("post_rst");
      chk("post_rst.alu_const", ALUResultM, 32'h3);

      // Random instructions
      for (int i = 0; i < 300; i++) begin
         RegWriteE    = 1'($urandom);
         ALUSrcE      = 1'($urandom);
         MemWriteE    = 1'($urandom);
         BranchE      = 1'($urandom);
         JumpE        = ($urandom_range(0, 7) == 0);
         PCResultSrcE = 1'($urandom);
         ResultSrcE   = 3'($urandom);
         DexControlE  = 3'($urandom);
         ALUControlE  = 4'($urandom);
         RD2_E        = $urandom;
         RD1_E        = ($urandom_range(0, 3) == 0) ? RD2_E : $urandom;
         Imm_Ext_E    = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
         PCE          = $urandom;
         PCPlus4E     = PCE + 32'd4;
         RD_E         = 5'($urandom);
         ForwardAE    = 2'($urandom);
         ForwardBE    = 2'($urandom);
         ResultW      = $urandom;
         step("rand");
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/execute_cycle.md
EXECUTE_CYCLE -- requirements
Module: execute_cycle

Interface
REQ-001 SHALL have the following ports (name  direction  width  meaning):
- CLK  in  1  clock; rising edge active
- Rst  in  1  reset; asynchronous, active-low
- RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE, PCResultSrcE  in  1 each  ID/EX control bits
- ResultSrcE  in  3  writeback select, passed through
- DexControlE  in  3  funct3: branch condition here, load/store size downstream
- ALUControlE  in  4  ALU op
- RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  in  32 each  ID/EX data
- RD_E  in  5  destination register
- ForwardAE, ForwardBE  in  2 each  operand A and B forward selects
- ResultW  in  32  writeback-stage result
- PCSrcE  out  1  redirect PC (combinational)
- PCTargetE  out  32  redirect target (combinational)
- RegWriteM, MemWriteM  out  1 each  EX/MEM control
- ResultSrcM, DexControlM  out  3 each  EX/MEM control
- ALUResultM, WriteDataM, Imm_Ext_M, PCPlus4M  out  32 each  EX/MEM data
- RD_M  out  5  EX/MEM destination

Function
REQ-002 Forward select SHALL be: 00 = RDx_E, 01 = ResultW, 10 = ALUResultM (this block's own register), 11 = treated as 00; applies to SrcA (from RD1_E) and FwdB (from RD2_E).
REQ-003 SrcB SHALL be Imm_Ext_E when ALUSrcE=1, otherwise FwdB.
REQ-004 ALUControlE SHALL decode as: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT (signed), 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA; 1010-1111 SHALL give result 0.
REQ-005 ADD and SUB SHALL wrap modulo 2^32 with no overflow flag.
REQ-006 Shift amount SHALL be SrcB[4:0]; SLT and SLTU SHALL give 32'd1 or 32'd0.
REQ-007 The branch compare SHALL use SrcA against FwdB (never the immediate).
REQ-008 Branch conditions by DexControlE: 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU; 010 and 011 SHALL never be taken.
REQ-009 PCSrcE SHALL be (BranchE AND condition) OR JumpE, with zero-cycle latency.
REQ-010 PCTargetE SHALL be {ALUResult[31:1],1'b0} when PCResultSrcE=1 (JALR), otherwise PCE+Imm_Ext_E modulo 2^32.
REQ-011 On each rising CLK with Rst high, the EX/MEM register SHALL capture:
- RegWriteE, MemWriteE, ResultSrcE, DexControlE, RD_E, PCPlus4E, Imm_Ext_E unchanged
- ALU result into ALUResultM
- FwdB into WriteDataM
Latency is one cycle.
REQ-012 A taken branch or jump SHALL still register its own EX/MEM entry (a JAL/JALR link write proceeds); flushing younger instructions is outside this block.
REQ-013 PCSrcE and PCTargetE SHALL be purely combinational and unaffected by Rst except through ALUResultM forwarding.

Reset
REQ-014 Rst low SHALL immediately (asynchronously) clear every M-stage output to 0, including RegWriteM=0 and MemWriteM=0.
REQ-015 Rst asserted mid-operation SHALL discard the in-flight EX/MEM entry with no partial write-enable left high.
REQ-016 The first rising CLK after Rst deasserts SHALL capture the current E inputs normally.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- ADD: RD1_E=0xFFFFFFFF, RD2_E=1, ALUSrcE=0, ALUControlE=0000 -> ALUResultM=0x00000000 one cycle later.
- Forwarding: ForwardAE=10, previous ALUResultM=0x10, RD1_E=0x99, Imm_Ext_E=4, ALUSrcE=1, ADD -> ALUResultM=0x14; ForwardBE=01, ResultW=0xAB, MemWriteE=1 -> WriteDataM=0xAB.
- Branch: BLT, SrcA=0x80000000, FwdB=1, BranchE=1, PCE=0x100, Imm=0xFFFFFFF8 -> PCSrcE=1, PCTargetE=0xF8; same operands with BLTU -> PCSrcE=0.
- JALR: JumpE=1, PCResultSrcE=1, SrcA=0x203, Imm=0x10, ADD, PCPlus4E=0x44, RegWriteE=1 -> PCTargetE=0x212; next cycle PCPlus4M=0x44, RegWriteM=1.
- SRA: SrcA=0x80000000, SrcB=0x21 -> shift by 1, ALUResultM=0xC0000000; ALUControlE=1111 -> ALUResultM=0.
- Reset: Rst pulsed low between clock edges while RegWriteM=1 and MemWriteM=1 -> both 0 immediately; all M outputs 0 until the first capture edge after release.
